// File: rtl/uart_cmd_responder.sv
// UART command responder: assembles two received bytes into a 16-bit command
// and independently serialises a response byte back to the initiator.
module uart_cmd_responder #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned TIMEOUT  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic       rx_meta, rx_sync, rx_prev, rx_fall;
  logic [1:0] rx_fill;

  // rx_prev only tracks the line once the synchronizer holds real samples, so
  // a line already low at reset release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b0;
      rx_fill <= '0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      if (rx_fill != 2'd2) rx_fill <= rx_fill + 2'd1;
      rx_prev <= (rx_fill == 2'd2) ? rx_sync : 1'b0;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  rx_state_t     rx_state;
  logic [BW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_sample, byte_stb;

  assign rx_sample = (rx_state == RX_RECV) && (rx_baud == '0);
  assign byte_stb  = rx_sample && (rx_bit == 4'd9) && rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_RECV;
            rx_baud  <= BAUD_HALF;
            rx_bit   <= '0;
          end
        end
        RX_RECV: begin
          if (rx_baud != '0) begin
            rx_baud <= rx_baud - BW'(1);
          end else begin
            rx_baud <= BAUD_LAST;
            rx_bit  <= rx_bit + 4'd1;
            if (rx_bit == 4'd0) begin
              if (rx_sync) rx_state <= RX_IDLE;
            end else if (rx_bit == 4'd9) begin
              rx_state <= RX_IDLE;
            end else begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  asm_state_t    asm_state;
  logic [7:0]    hi_byte;
  logic [TW-1:0] tmo_cnt;

  // Byte strobe acts on the stop-sample edge itself, so cmd/cmd_rdy appear
  // the cycle after the stop bit is sampled; a set overrides clr_cmd_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_state <= WAIT_HIGH;
      hi_byte   <= '0;
      tmo_cnt   <= '0;
      cmd       <= '0;
      cmd_rdy   <= 1'b0;
    end else begin
      if (clr_cmd_rdy) cmd_rdy <= 1'b0;
      case (asm_state)
        WAIT_HIGH: begin
          if (byte_stb) begin
            hi_byte   <= rx_shift;
            cmd_rdy   <= 1'b0;
            tmo_cnt   <= '0;
            asm_state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (byte_stb) begin
            cmd       <= {hi_byte, rx_shift};
            cmd_rdy   <= 1'b1;
            asm_state <= WAIT_HIGH;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_cnt   <= '0;
            asm_state <= WAIT_HIGH;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: asm_state <= WAIT_HIGH;
      endcase
    end
  end

  tx_state_t     tx_state;
  logic [9:0]    tx_shift;
  logic [BW-1:0] tx_baud;
  logic [3:0]    tx_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_shift <= '1;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_done  <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift <= {1'b1, resp, 1'b0};
            tx_done  <= 1'b0;
            tx_baud  <= BAUD_LAST;
            tx_bit   <= '0;
            tx_state <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (tx_baud != '0) begin
            tx_baud <= tx_baud - BW'(1);
          end else if (tx_bit == 4'd9) begin
            tx_shift <= '1;
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_shift <= {1'b1, tx_shift[9:1]};
            tx_bit   <= tx_bit + 4'd1;
            tx_baud  <= BAUD_LAST;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign TX = tx_shift[0];

endmodule
